// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
//   Shares one single-port RAM between instruction fetch (IF) and the MEM-stage
//   load/store port (DM). Every access goes through a fixed-latency memory. DM
//   has strict priority over IF. The pipeline stalls while a data access is
//   pending.
//
// Ports
//   clk, rst          clock; asynchronous active-high reset
//   if_req/if_addr    fetch request (held until if_valid) and word address
//   if_valid/if_rdata one-cycle completion pulse and fetched word
//   dm_read_flag      001 lw, 110 lh, 111 lb, 011 lbu, 010 lhu, 000 none
//   dm_write_flag     01 sw, 10 sh, 11 sb, 00 none (a write overrides a read)
//   dm_addr/dm_wdata  byte address and store data
//   dm_done/dm_rdata  one-cycle completion pulse and extended load data
//   dm_misalign       pulses with dm_done when the access was rejected
//   stall             data request pending and not completing this cycle
//   mem_*             RAM strobe, byte write enables, word address, write data
//                     and read word (valid MEM_LATENCY cycles after mem_en)
//
// Parameters
//   MEM_LATENCY       cycles from the mem_en cycle to mem_rdata valid (1..4)

module mem_port_arbiter #(
  parameter int MEM_LATENCY = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  output logic        if_valid,
  output logic [31:0] if_rdata,
  input  logic [2:0]  dm_read_flag,
  input  logic [1:0]  dm_write_flag,
  input  logic [31:0] dm_addr,
  input  logic [31:0] dm_wdata,
  output logic        dm_done,
  output logic [31:0] dm_rdata,
  output logic        dm_misalign,
  output logic        stall,
  output logic        mem_en,
  output logic [3:0]  mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata
);

  localparam logic [2:0] RD_NONE = 3'b000;
  localparam logic [2:0] RD_LW   = 3'b001;
  localparam logic [2:0] RD_LHU  = 3'b010;
  localparam logic [2:0] RD_LBU  = 3'b011;
  localparam logic [2:0] RD_LH   = 3'b110;
  localparam logic [2:0] RD_LB   = 3'b111;

  localparam logic [1:0] WR_SW = 2'b01;
  localparam logic [1:0] WR_SH = 2'b10;
  localparam logic [1:0] WR_SB = 2'b11;

  // WAIT is left in the cycle mem_rdata is valid, so it counts down from L-1.
  localparam logic [1:0] CNT_INIT = 2'(MEM_LATENCY - 1);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

  state_t      state;
  logic        owner_dm;   // 1: access belongs to DM, 0: to IF
  logic        wr_q;       // latched: access is a store
  logic [2:0]  rd_q;       // latched load type (DM only)
  logic [1:0]  lo_q;       // latched byte offset for lane selection
  logic [1:0]  cnt;

  // ---------------------------------------------------------------------------
  // Request decode
  // ---------------------------------------------------------------------------
  logic        dm_wr, dm_rd, dm_req, dm_mis;
  logic [31:0] req_addr;
  logic [3:0]  st_we;
  logic [31:0] st_wdata;

  assign dm_wr    = |dm_write_flag;
  assign dm_rd    = |dm_read_flag;
  assign dm_req   = dm_wr | dm_rd;
  assign req_addr = dm_req ? dm_addr : if_addr;

  // Misalignment is judged on the access width; the write flag wins.
  always_comb begin
    dm_mis = 1'b0;
    if (dm_wr) begin
      case (dm_write_flag)
        WR_SW:   dm_mis = |dm_addr[1:0];
        WR_SH:   dm_mis = dm_addr[0];
        default: dm_mis = 1'b0;
      endcase
    end else if (dm_rd) begin
      case (dm_read_flag)
        RD_LH, RD_LHU: dm_mis = dm_addr[0];
        RD_LB, RD_LBU: dm_mis = 1'b0;
        default:       dm_mis = |dm_addr[1:0];
      endcase
    end
  end

  // Store lanes: data is replicated across the word so the enabled lane
  // always sees the right bytes regardless of offset.
  always_comb begin
    st_we    = 4'b0000;
    st_wdata = dm_wdata;
    case (dm_write_flag)
      WR_SW: begin
        st_we    = 4'b1111;
        st_wdata = dm_wdata;
      end
      WR_SH: begin
        st_we    = 4'b0011 << dm_addr[1:0];
        st_wdata = {2{dm_wdata[15:0]}};
      end
      WR_SB: begin
        st_we    = 4'b0001 << dm_addr[1:0];
        st_wdata = {4{dm_wdata[7:0]}};
      end
      default: begin
        st_we    = 4'b0000;
        st_wdata = dm_wdata;
      end
    endcase
  end

  // Load lane select and extension.
  function automatic logic [31:0] load_ext(input logic [2:0]  fl,
                                           input logic [1:0]  lo,
                                           input logic [31:0] w);
    logic [7:0]  b;
    logic [15:0] h;
    b = w[{lo, 3'b000} +: 8];
    h = lo[1] ? w[31:16] : w[15:0];
    case (fl)
      RD_LB:   return {{24{b[7]}}, b};
      RD_LBU:  return {24'h0, b};
      RD_LH:   return {{16{h[15]}}, h};
      RD_LHU:  return {16'h0, h};
      default: return w;
    endcase
  endfunction

  // Reset forces stall low as well, so every output is 0 during reset.
  assign stall = dm_req & ~dm_done & ~rst;

  // ---------------------------------------------------------------------------
  // Sequencer. All outputs except stall are registered here; completion
  // pulses are set on entry to RESP and cleared on leaving it.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      owner_dm    <= 1'b0;
      wr_q        <= 1'b0;
      rd_q        <= RD_NONE;
      lo_q        <= 2'b00;
      cnt         <= 2'd0;
      if_valid    <= 1'b0;
      if_rdata    <= 32'h0;
      dm_done     <= 1'b0;
      dm_rdata    <= 32'h0;
      dm_misalign <= 1'b0;
      mem_en      <= 1'b0;
      mem_we      <= 4'b0000;
      mem_addr    <= 32'h0;
      mem_wdata   <= 32'h0;
    end else begin
      case (state)
        IDLE: begin
          if (dm_req && dm_mis) begin
            // Rejected without touching the memory.
            dm_done     <= 1'b1;
            dm_misalign <= 1'b1;
            dm_rdata    <= 32'h0;
            state       <= RESP;
          end else if (dm_req || if_req) begin
            owner_dm <= dm_req;
            wr_q     <= dm_req & dm_wr;
            rd_q     <= (dm_req && !dm_wr) ? dm_read_flag : RD_NONE;
            lo_q     <= req_addr[1:0];
            mem_en   <= 1'b1;
            mem_addr <= {req_addr[31:2], 2'b00};
            if (dm_req && dm_wr) begin
              mem_we    <= st_we;
              mem_wdata <= st_wdata;
            end else begin
              mem_we    <= 4'b0000;
            end
            state <= ISSUE;
          end
        end

        ISSUE: begin
          mem_en <= 1'b0;
          mem_we <= 4'b0000;
          if (wr_q) begin
            dm_done <= 1'b1;
            state   <= RESP;
          end else begin
            cnt   <= CNT_INIT;
            state <= WAIT;
          end
        end

        WAIT: begin
          if (cnt == 2'd0) begin
            if (owner_dm) begin
              dm_done  <= 1'b1;
              dm_rdata <= load_ext(rd_q, lo_q, mem_rdata);
            end else begin
              if_valid <= 1'b1;
              if_rdata <= mem_rdata;
            end
            state <= RESP;
          end else begin
            cnt <= cnt - 2'd1;
          end
        end

        RESP: begin
          if_valid    <= 1'b0;
          dm_done     <= 1'b0;
          dm_misalign <= 1'b0;
          state       <= IDLE;
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: two instances (MEM_LATENCY 1 and 3), each with
// its own RAM model and a transaction-level reference that predicts, from the
// request and the access width, in which cycle each bus event and completion
// must happen and what data it carries.

module tb_mem_port_arbiter;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_cmp = 0;
  int n_bad = 0;

  logic [1:0]            if_req;
  logic [1:0][31:0]      if_addr, dm_addr, dm_wdata;
  logic [1:0][2:0]       dm_read_flag;
  logic [1:0][1:0]       dm_write_flag;
  logic [1:0]            if_valid, dm_done, dm_misalign, stall, mem_en;
  logic [1:0][31:0]      if_rdata, dm_rdata, mem_addr, mem_wdata;
  logic [1:0][3:0]       mem_we;

  logic                  pre_we;
  logic [6:0]            pre_idx;
  logic [31:0]           pre_dat;

  // results of the last directed operation
  int                    r_lat, r_en;
  logic [31:0]           r_rd, r_ma, r_wd;
  logic [3:0]            r_we;
  logic                  r_mis;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic fail(input string nm);
    n_cmp++;
    n_bad++;
    $display("FAIL %s: expected event never came (t=%0t)", nm, $time);
  endtask

  for (genvar k = 0; k < 2; k++) begin : g_inst
    localparam int L = (k == 0) ? 1 : 3;

    logic [31:0] mem [128];
    logic [4:1]  pv = '0;
    logic [31:0] pd [1:4];
    logic [31:0] junk;
    logic [31:0] mem_rdata;

    mem_port_arbiter #(.MEM_LATENCY(L)) dut (
      .clk(clk), .rst(rst),
      .if_req(if_req[k]), .if_addr(if_addr[k]),
      .if_valid(if_valid[k]), .if_rdata(if_rdata[k]),
      .dm_read_flag(dm_read_flag[k]), .dm_write_flag(dm_write_flag[k]),
      .dm_addr(dm_addr[k]), .dm_wdata(dm_wdata[k]),
      .dm_done(dm_done[k]), .dm_rdata(dm_rdata[k]), .dm_misalign(dm_misalign[k]),
      .stall(stall[k]),
      .mem_en(mem_en[k]), .mem_we(mem_we[k]), .mem_addr(mem_addr[k]),
      .mem_wdata(mem_wdata[k]), .mem_rdata(mem_rdata)
    );

    // RAM: read word appears exactly L cycles after the mem_en cycle, noise otherwise.
    always @(posedge clk) begin
      if (pre_we) mem[pre_idx] <= pre_dat;
      if (mem_en[k])
        for (int b = 0; b < 4; b++)
          if (mem_we[k][b]) mem[mem_addr[k][8:2]][8*b +: 8] <= mem_wdata[k][8*b +: 8];
      pv[1] <= mem_en[k] && (mem_we[k] == 4'b0000);
      pd[1] <= mem[mem_addr[k][8:2]];
      for (int i = 2; i <= 4; i++) begin
        pv[i] <= pv[i-1];
        pd[i] <= pd[i-1];
      end
      junk <= $urandom;
    end
    assign mem_rdata = pv[L] ? pd[L] : junk;

    // Reference: schedule of expected events for the transaction in flight.
    int          en_c = -1, dm_c = -1, if_c = -1, free_c = 0;
    logic [3:0]  e_we;
    logic [31:0] e_addr, e_wd, e_dm, e_if;
    logic        e_mis, e_ld;

    always @(posedge clk) begin
      int          nb;
      logic [31:0] a, d, w;
      logic        wr, sgn;
      longint      v;
      if (rst) begin
        en_c = -1; dm_c = -1; if_c = -1; free_c = 0;
      end else if (cyc >= free_c) begin
        if (dm_read_flag[k] != 3'b000 || dm_write_flag[k] != 2'b00) begin
          a  = dm_addr[k];
          d  = dm_wdata[k];
          wr = dm_write_flag[k] != 2'b00;
          if (wr) nb = (dm_write_flag[k] == 2'b01) ? 4 : (dm_write_flag[k] == 2'b10) ? 2 : 1;
          else    nb = (dm_read_flag[k] == 3'b001) ? 4 :
                       (dm_read_flag[k] == 3'b110 || dm_read_flag[k] == 3'b010) ? 2 : 1;
          sgn = dm_read_flag[k] == 3'b111 || dm_read_flag[k] == 3'b110;
          if (a % nb != 0) begin
            en_c = -1; dm_c = cyc + 1; free_c = cyc + 2;
            e_mis = 1'b1; e_ld = 1'b1; e_dm = 32'h0;
          end else begin
            e_mis  = 1'b0;
            en_c   = cyc + 1;
            e_addr = a & 32'hFFFF_FFFC;
            if (wr) begin
              e_we  = 4'(((1 << nb) - 1) << (a % 4));
              e_wd  = (nb == 4) ? d : (nb == 2) ? {16'h0, d[15:0]} * 32'h0001_0001
                                                : {24'h0, d[7:0]} * 32'h0101_0101;
              e_ld  = 1'b0;
              dm_c  = cyc + 2; free_c = cyc + 3;
            end else begin
              w = mem[a[8:2]];
              v = (longint'(w) >> (8 * (a % 4))) & ((64'd1 << (8 * nb)) - 1);
              if (sgn && nb < 4 && v >= (64'd1 << (8 * nb - 1))) v = v - (64'd1 << (8 * nb));
              e_dm = v[31:0];
              e_we = 4'b0000; e_ld = 1'b1;
              dm_c = cyc + 2 + L; free_c = cyc + 3 + L;
            end
          end
        end else if (if_req[k]) begin
          en_c   = cyc + 1;
          e_addr = if_addr[k] & 32'hFFFF_FFFC;
          e_we   = 4'b0000;
          e_if   = mem[if_addr[k][8:2]];
          if_c   = cyc + 2 + L; free_c = cyc + 3 + L;
        end
      end
    end

    always @(negedge clk) begin
      string p;
      p = (k == 0) ? "L1" : "L3";
      if (rst) begin
        chk({p, " rst mem_en"}, 32'(mem_en[k]), 32'h0);
        chk({p, " rst dm_done"}, 32'(dm_done[k]), 32'h0);
        chk({p, " rst if_valid"}, 32'(if_valid[k]), 32'h0);
        chk({p, " rst stall"}, 32'(stall[k]), 32'h0);
      end else begin
        chk({p, " mem_en"}, 32'(mem_en[k]), 32'(cyc == en_c));
        chk({p, " mem_we"}, 32'(mem_we[k]), 32'((cyc == en_c) ? e_we : 4'b0000));
        if (cyc == en_c) begin
          chk({p, " mem_addr"}, mem_addr[k], e_addr);
          if (e_we != 4'b0000) chk({p, " mem_wdata"}, mem_wdata[k], e_wd);
        end
        chk({p, " dm_done"}, 32'(dm_done[k]), 32'(cyc == dm_c));
        chk({p, " dm_misalign"}, 32'(dm_misalign[k]), 32'(cyc == dm_c && e_mis));
        if (cyc == dm_c && e_ld) chk({p, " dm_rdata"}, dm_rdata[k], e_dm);
        chk({p, " if_valid"}, 32'(if_valid[k]), 32'(cyc == if_c));
        if (cyc == if_c) chk({p, " if_rdata"}, if_rdata[k], e_if);
        chk({p, " stall"}, 32'(stall[k]),
            32'((dm_read_flag[k] != 3'b000 || dm_write_flag[k] != 2'b00) && cyc != dm_c));
      end
    end
  end

  task automatic preload(input logic [6:0] i, input logic [31:0] d);
    pre_idx = i; pre_dat = d; pre_we = 1'b1;
    @(posedge clk); #1;
    pre_we = 1'b0;
  endtask

  // Called at posedge+1; cycle 0 is the cycle the request is first presented.
  task automatic dm_op(input int k, input logic [2:0] rf, input logic [1:0] wf,
                       input logic [31:0] a, input logic [31:0] d);
    int t0;
    t0 = cyc; r_lat = -1; r_en = -1; r_rd = '0; r_mis = 1'b0;
    r_we = '0; r_ma = '0; r_wd = '0;
    dm_read_flag[k] = rf; dm_write_flag[k] = wf; dm_addr[k] = a; dm_wdata[k] = d;
    for (int i = 0; i < 20 && r_lat < 0; i++) begin
      @(negedge clk);
      if (mem_en[k]) begin
        r_en = cyc - t0; r_we = mem_we[k]; r_ma = mem_addr[k]; r_wd = mem_wdata[k];
      end
      if (dm_done[k]) begin
        r_lat = cyc - t0; r_rd = dm_rdata[k]; r_mis = dm_misalign[k];
      end
    end
    if (r_lat < 0) fail("dm_op completion");
    @(posedge clk); #1;
    dm_read_flag[k] = 3'b000; dm_write_flag[k] = 2'b00;
  endtask

  task automatic if_op(input int k, input logic [31:0] a);
    int t0;
    t0 = cyc; r_lat = -1; r_rd = '0;
    if_req[k] = 1'b1; if_addr[k] = a;
    for (int i = 0; i < 20 && r_lat < 0; i++) begin
      @(negedge clk);
      if (if_valid[k]) begin r_lat = cyc - t0; r_rd = if_rdata[k]; end
    end
    if (r_lat < 0) fail("if_op completion");
    @(posedge clk); #1;
    if_req[k] = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int t0, dl, il;
    logic [31:0] dd, id;
    if_req = '0; if_addr = '0; dm_addr = '0; dm_wdata = '0;
    dm_read_flag = '0; dm_write_flag = '0;
    pre_we = 1'b0; pre_idx = '0; pre_dat = '0;
    #2;
    for (int k = 0; k < 2; k++) begin
      chk("reset mem_en", 32'(mem_en[k]), 32'h0);
      chk("reset mem_we", 32'(mem_we[k]), 32'h0);
      chk("reset mem_addr", mem_addr[k], 32'h0);
      chk("reset dm_rdata", dm_rdata[k], 32'h0);
      chk("reset if_rdata", if_rdata[k], 32'h0);
      chk("reset stall", 32'(stall[k]), 32'h0);
    end
    preload(7'd16, 32'hDEAD_BEEF);
    preload(7'd17, 32'hCAFE_0001);
    preload(7'd64, 32'h1111_1111);
    preload(7'd8,  32'h0);
    rst = 1'b0;
    @(posedge clk); #1;

    // ---- MEM_LATENCY = 1 ----
    dm_op(0, 3'b001, 2'b00, 32'h40, 32'h0);
    chk("lw latency", r_lat, 3);
    chk("lw mem_en cycle", r_en, 1);
    chk("lw mem_addr", r_ma, 32'h40);
    chk("lw data", r_rd, 32'hDEAD_BEEF);

    preload(7'd16, 32'h80FF_1234);
    dm_op(0, 3'b111, 2'b00, 32'h43, 32'h0);
    chk("lb 0x43", r_rd, 32'hFFFF_FF80);
    dm_op(0, 3'b011, 2'b00, 32'h43, 32'h0);
    chk("lbu 0x43", r_rd, 32'h0000_0080);
    dm_op(0, 3'b110, 2'b00, 32'h42, 32'h0);
    chk("lh 0x42", r_rd, 32'hFFFF_80FF);
    dm_op(0, 3'b010, 2'b00, 32'h42, 32'h0);
    chk("lhu 0x42", r_rd, 32'h0000_80FF);
    dm_op(0, 3'b111, 2'b00, 32'h40, 32'h0);
    chk("lb 0x40 positive", r_rd, 32'h0000_0034);
    dm_op(0, 3'b001, 2'b00, 32'h43, 32'h0);
    chk("lw misaligned latency", r_lat, 1);
    chk("lw misaligned flag", 32'(r_mis), 32'h1);
    chk("lw misaligned data", r_rd, 32'h0);
    dm_op(0, 3'b110, 2'b00, 32'h41, 32'h0);
    chk("lh misaligned flag", 32'(r_mis), 32'h1);

    dm_op(0, 3'b000, 2'b10, 32'h102, 32'h0000_ABCD);
    chk("sh latency", r_lat, 2);
    chk("sh mem_addr", r_ma, 32'h100);
    chk("sh mem_we", 32'(r_we), 32'hC);
    chk("sh mem_wdata", r_wd, 32'hABCD_ABCD);
    dm_op(0, 3'b001, 2'b00, 32'h100, 32'h0);
    chk("sh readback", r_rd, 32'hABCD_1111);
    dm_op(0, 3'b000, 2'b11, 32'h101, 32'h0000_005A);
    chk("sb mem_we", 32'(r_we), 32'h2);
    chk("sb mem_wdata", r_wd, 32'h5A5A_5A5A);
    dm_op(0, 3'b000, 2'b01, 32'h101, 32'h7777_7777);
    chk("sw misaligned latency", r_lat, 1);
    chk("sw misaligned flag", 32'(r_mis), 32'h1);
    chk("sw misaligned no mem_en", r_en, -1);
    dm_op(0, 3'b001, 2'b00, 32'h100, 32'h0);
    chk("word after sb / rejected sw", r_rd, 32'hABCD_5A11);

    dm_op(0, 3'b001, 2'b01, 32'h20, 32'h1234_5678);
    chk("write wins latency", r_lat, 2);
    chk("write wins mem_we", 32'(r_we), 32'hF);
    dm_op(0, 3'b001, 2'b00, 32'h20, 32'h0);
    chk("write wins readback", r_rd, 32'h1234_5678);

    if_op(0, 32'h41);
    chk("fetch latency", r_lat, 3);
    chk("fetch data", r_rd, 32'h80FF_1234);

    // ---- MEM_LATENCY = 3: DM and IF presented together ----
    t0 = cyc; dl = -1; il = -1; dd = '0; id = '0;
    if_req[1] = 1'b1; if_addr[1] = 32'h40;
    dm_read_flag[1] = 3'b001; dm_addr[1] = 32'h100;
    for (int i = 0; i < 30 && dl < 0; i++) begin
      @(negedge clk);
      if (dm_done[1]) begin dl = cyc - t0; dd = dm_rdata[1]; end
    end
    if (dl < 0) fail("priority dm_done");
    @(posedge clk); #1;
    dm_read_flag[1] = 3'b000;
    for (int i = 0; i < 30 && il < 0; i++) begin
      @(negedge clk);
      if (if_valid[1]) begin il = cyc - t0; id = if_rdata[1]; end
    end
    if (il < 0) fail("priority if_valid");
    @(posedge clk); #1;
    if_req[1] = 1'b0;
    chk("priority dm cycle", dl, 5);
    chk("priority dm data", dd, 32'h1111_1111);
    chk("priority if cycle", il, 11);
    chk("priority if data", id, 32'h80FF_1234);

    // ---- reset in the middle of WAIT ----
    dm_read_flag[1] = 3'b001; dm_addr[1] = 32'h100;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    chk("mid rst mem_en", 32'(mem_en[1]), 32'h0);
    chk("mid rst dm_done", 32'(dm_done[1]), 32'h0);
    chk("mid rst stall", 32'(stall[1]), 32'h0);
    chk("mid rst dm_rdata", dm_rdata[1], 32'h0);
    chk("mid rst if_rdata", if_rdata[1], 32'h0);
    chk("mid rst mem_addr", mem_addr[1], 32'h0);
    dm_read_flag[1] = 3'b000;
    @(posedge clk); #1;
    rst = 1'b0;
    dm_op(1, 3'b001, 2'b00, 32'h44, 32'h0);
    chk("post rst lw latency", r_lat, 5);
    chk("post rst lw data", r_rd, 32'hCAFE_0001);

    repeat (3) @(posedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
